stage_sequencer: RTL and testbench

Multi-cycle stage sequencer that sits directly upstream of the control unit. It generates the five stage strobes IF_clk, ID_clk, ALU_clk, MEM_clk and RB_BR_clk from the single system clock. It watches the control unit's halt encoding (branch_opcode) and its interrupt request, and freezes or diverts the sequence in response. It also arbitrates start and restart of execution and exposes run status to the top level.

---
 rtl/stage_sequencer.sv | 174 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle stage strobe generator placed in front of the
// control unit. One instruction is split into five phases (IF, ID, ALU, MEM,
// RB) of PHASE_CYCLES clocks each. Each phase's strobe is high for the first
// cycle of that phase. An interrupt seen at the end of ID diverts the sequence
// into INT_WAIT until the handler acknowledges. A halt branch code seen at the
// end of ALU freezes the sequence in HALTED until the next start.
// Optional feature macro: SEQ_MEM_WAIT_EN. When it is defined, the MEM phase
// stretches until mem_ready is seen high.

module stage_sequencer #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       interrupt,
  input  logic [2:0] branch_opcode,
  input  logic       int_ack,
  input  logic       mem_ready,
  output logic       IF_clk,
  output logic       ID_clk,
  output logic       ALU_clk,
  output logic       MEM_clk,
  output logic       RB_BR_clk,
  output logic [2:0] phase,
  output logic       busy,
  output logic       halted,
  output logic       int_req,
  output logic       instr_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_INT_WAIT,
    S_HALTED
  } state_t;

  localparam logic [3:0] SUB_LAST = 4'(PHASE_CYCLES - 1);

  localparam logic [2:0] PH_IF   = 3'd0;
  localparam logic [2:0] PH_ID   = 3'd1;
  localparam logic [2:0] PH_ALU  = 3'd2;
  localparam logic [2:0] PH_MEM  = 3'd3;
  localparam logic [2:0] PH_RB   = 3'd4;
  localparam logic [2:0] PH_NONE = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] sub_q, sub_d;
  logic [4:0] strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       int_req_q, int_req_d;
  logic       instr_done_q, instr_done_d;

`ifndef SEQ_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  // Next-state logic: sequencing, interrupt/halt diversion and the outputs
  // derived from the upcoming state so that every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    sub_d    = sub_q;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          phase_d = PH_IF;
          sub_d   = 4'd0;
        end
      end

      S_RUN: begin
        if (sub_q != SUB_LAST) begin
          sub_d = sub_q + 4'd1;
        end
`ifdef SEQ_MEM_WAIT_EN
        else if ((phase_q == PH_MEM) && !mem_ready) begin
          sub_d = sub_q;
        end
`endif
        else begin
          sub_d = 4'd0;
          case (phase_q)
            PH_IF:  phase_d = PH_ID;
            PH_ID: begin
              if (interrupt) begin
                state_d = S_INT_WAIT;
                phase_d = PH_ID;
              end else begin
                phase_d = PH_ALU;
              end
            end
            PH_ALU: begin
              if (branch_opcode == 3'b000) begin
                state_d = S_HALTED;
                phase_d = PH_NONE;
              end else begin
                phase_d = PH_MEM;
              end
            end
            PH_MEM: phase_d = PH_RB;
            PH_RB:  phase_d = PH_IF;
            default: phase_d = PH_IF;
          endcase
        end
      end

      S_INT_WAIT: begin
        if (int_ack) begin
          state_d = S_RUN;
          phase_d = PH_IF;
          sub_d   = 4'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = PH_NONE;
        sub_d   = 4'd0;
      end
    endcase

    strobe_d = 5'b00000;
    if ((state_d == S_RUN) && (sub_d == 4'd0)) begin
      strobe_d = 5'b00001 << phase_d;
    end

    busy_d       = (state_d == S_RUN) || (state_d == S_INT_WAIT);
    halted_d     = (state_d == S_HALTED);
    int_req_d    = (state_d == S_INT_WAIT);
    instr_done_d = (state_d == S_RUN) && (phase_d == PH_RB) && (sub_d == SUB_LAST);
  end

  // State and output registers; reset clears every strobe without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_NONE;
      sub_q        <= 4'd0;
      strobe_q     <= 5'b00000;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      int_req_q    <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sub_q        <= sub_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      int_req_q    <= int_req_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign IF_clk     = strobe_q[0];
  assign ID_clk     = strobe_q[1];
  assign ALU_clk    = strobe_q[2];
  assign MEM_clk    = strobe_q[3];
  assign RB_BR_clk  = strobe_q[4];
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign int_req    = int_req_q;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer with PHASE_CYCLES=2.
// Expected output snapshots are queued as each cycle's stimulus is driven and
// popped for comparison one time unit after the following rising edge.

module tb_stage_sequencer;

  localparam int P = 2;

  typedef struct packed {
    logic [4:0] strobes;
    logic [2:0] phase;
    logic       busy;
    logic       halted;
    logic       int_req;
    logic       instr_done;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       interrupt;
  logic [2:0] branch_opcode;
  logic       int_ack;
  logic       mem_ready;
  logic       IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk;
  logic [2:0] phase;
  logic       busy, halted, int_req, instr_done;

  obs_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  stage_sequencer #(.PHASE_CYCLES(P)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .interrupt     (interrupt),
    .branch_opcode (branch_opcode),
    .int_ack       (int_ack),
    .mem_ready     (mem_ready),
    .IF_clk        (IF_clk),
    .ID_clk        (ID_clk),
    .ALU_clk       (ALU_clk),
    .MEM_clk       (MEM_clk),
    .RB_BR_clk     (RB_BR_clk),
    .phase         (phase),
    .busy          (busy),
    .halted        (halted),
    .int_req       (int_req),
    .instr_done    (instr_done)
  );

  // Free-running system clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected outputs k cycles after the start edge of an unstalled instruction.
  function automatic obs_t runExp(input int k);
    obs_t o;
    int   ph;
    int   s;
    ph = (k / P) % 5;
    s  = k % P;
    o = '0;
    o.phase = 3'(ph);
    o.strobes[ph] = (s == 0);
    o.busy = 1'b1;
    o.instr_done = (ph == 4) && (s == P - 1);
    return o;
  endfunction

  function automatic obs_t idleExp();
    obs_t o;
    o = '0;
    o.phase = 3'd7;
    return o;
  endfunction

  function automatic obs_t haltExp();
    obs_t o;
    o = '0;
    o.phase = 3'd7;
    o.halted = 1'b1;
    return o;
  endfunction

  function automatic obs_t intExp();
    obs_t o;
    o = '0;
    o.phase = 3'd1;
    o.busy = 1'b1;
    o.int_req = 1'b1;
    return o;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.strobes    = {RB_BR_clk, MEM_clk, ALU_clk, ID_clk, IF_clk};
    o.phase      = phase;
    o.busy       = busy;
    o.halted     = halted;
    o.int_req    = int_req;
    o.instr_done = instr_done;
    return o;
  endfunction

  task automatic checkOutput(input string tag);
    obs_t expv;
    obs_t got;
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: observed=empty-scoreboard required=entry", tag);
    end else begin
      expv = scoreboard.pop_front();
      got  = sampleDut();
      assert (got === expv) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%b required=%b (strobes|phase|busy|halted|int_req|instr_done)",
               tag, got, expv);
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic intr, input logic [2:0] br,
                               input logic ack, input logic mr, input obs_t expv,
                               input string tag);
    start         = st;
    interrupt     = intr;
    branch_opcode = br;
    int_ack       = ack;
    mem_ready     = mr;
    scoreboard.push_back(expv);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    obs_t stall_exp;
    rst = 1'b1;
    start = 1'b0;
    interrupt = 1'b0;
    branch_opcode = 3'b001;
    int_ack = 1'b0;
    mem_ready = 1'b1;

    #3;
    scoreboard.push_back(idleExp());
    checkOutput("reset_async");
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b1, idleExp(), "reset_held_start");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, idleExp(), "idle_no_start");

    // Start sequence, then a second instruction with start held high.
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b1, runExp(0), "start_if");
    for (int k = 1; k <= 10; k++)
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, runExp(k), "run_seq");
    for (int k = 11; k <= 19; k++)
      applyStimulus(1'b1, 1'b0, 3'b011, 1'b0, 1'b1, runExp(k), "start_ignored");

    // Halt code sampled at the end of ALU of the third instruction.
    for (int k = 20; k <= 25; k++)
      applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 1'b1, runExp(k), "pre_halt");
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, haltExp(), "halt_entry");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, haltExp(), "halt_hold");
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b1, runExp(0), "halt_restart");

    // Interrupt sampled at the end of ID; acknowledge resumes at IF.
    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, runExp(k), "pre_int");
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, intExp(), "int_entry");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, intExp(), "int_wait_hold");
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, runExp(0), "int_ack_resume");
    for (int k = 1; k <= 9; k++)
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, runExp(k), "post_int");

    // mem_ready low across the MEM phase, rising at E12.
    for (int j = 0; j <= 14; j++) begin
`ifdef SEQ_MEM_WAIT_EN
      stall_exp = runExp((j <= 7) ? j : ((j < 12) ? 7 : j - 4));
`else
      stall_exp = runExp(j);
`endif
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, !((j >= 6) && (j <= 11)), stall_exp, "mem_stall");
    end

    // Reset asserted in the middle of an ALU strobe cycle.
    rst = 1'b1;
    #1;
    scoreboard.push_back(idleExp());
    checkOutput("reset_from_run");
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, idleExp(), "reset_idle");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b1, runExp(0), "restart_if");
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, runExp(k), "pre_reset");
    #1;
    rst = 1'b1;
    #1;
    scoreboard.push_back(idleExp());
    checkOutput("reset_mid_run");
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b1, idleExp(), "reset_ignores_inputs");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, idleExp(), "post_reset_idle");
    applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b1, runExp(0), "post_reset_start");
    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1, runExp(k), "post_reset_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
